pw_pattern_sequencer: RTL and testbench

// - Multi-stage trigger sequencer in the fe_clk domain that drives pw_pattern_matcher.
// - Loads one stage's pattern, mask and length into the matcher, arms it, and waits for O_match.
// - On a match it clears the matcher and advances to the next stage; after the last stage it fires a 1-cycle trigger.
// - An optional inter-stage window returns the sequence to stage 0 if the next match arrives too late.

---
 rtl/pw_pattern_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_pw_pattern_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_pattern_sequencer.sv
// Multi-stage trigger sequencer driving pw_pattern_matcher in the fe_clk domain.
// Optional per-stage match repeat counts are enabled with `define PW_SEQ_REPEAT_EN.
module pw_pattern_sequencer #(
  parameter int pPATTERN_BYTES = 8,
  parameter int pSTAGES        = 4,
  parameter int pWINDOW_BITS   = 16
) (
  input  logic                                fe_clk,
  input  logic                                reset_n,
  input  logic                                I_arm,
  input  logic [7:0]                          I_num_stages,
  input  logic [pSTAGES*pPATTERN_BYTES*8-1:0] I_stage_pattern,
  input  logic [pSTAGES*pPATTERN_BYTES*8-1:0] I_stage_mask,
  input  logic [pSTAGES*8-1:0]                I_stage_bytes,
  input  logic [pWINDOW_BITS-1:0]             I_window,
  input  logic                                I_match,
`ifdef PW_SEQ_REPEAT_EN
  input  logic [pSTAGES*8-1:0]                I_stage_repeat,
  output logic [7:0]                          O_repeat_cnt,
`endif
  output logic                                O_pm_arm,
  output logic [pPATTERN_BYTES*8-1:0]         O_pm_pattern,
  output logic [pPATTERN_BYTES*8-1:0]         O_pm_mask,
  output logic [7:0]                          O_pm_bytes,
  output logic                                O_pm_clear,
  output logic                                O_trigger,
  output logic                                O_timeout,
  output logic [7:0]                          O_stage,
  output logic                                O_busy
);

  localparam int PW = pPATTERN_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CLEAR,
    S_FIRE,
    S_DONE
  } state_t;

  state_t                  state, state_nx;
  logic [7:0]              stage, stage_nx;
  logic [7:0]              num_stages, num_stages_nx, num_clamped;
  logic [pWINDOW_BITS-1:0] win_cnt, win_cnt_nx;
  logic                    timeout_nx;
  logic [PW-1:0]           sel_pattern, sel_mask;
  logic [7:0]              sel_bytes;
  logic                    last_stage, win_active, win_expired, stage_done;

`ifdef PW_SEQ_REPEAT_EN
  logic [7:0] rep_cnt, rep_cnt_nx, rep_target, sel_repeat;
`endif

  always_comb begin
    if (I_num_stages == 8'd0)
      num_clamped = 8'd1;
    else if (I_num_stages > 8'(pSTAGES))
      num_clamped = 8'(pSTAGES);
    else
      num_clamped = I_num_stages;
  end

  always_comb begin
    sel_pattern = '0;
    sel_mask    = '0;
    sel_bytes   = '0;
`ifdef PW_SEQ_REPEAT_EN
    sel_repeat  = '0;
`endif
    for (int unsigned k = 0; k < pSTAGES; k++) begin
      if (stage == 8'(k)) begin
        sel_pattern = I_stage_pattern[k*PW +: PW];
        sel_mask    = I_stage_mask[k*PW +: PW];
        sel_bytes   = I_stage_bytes[k*8 +: 8];
`ifdef PW_SEQ_REPEAT_EN
        sel_repeat  = I_stage_repeat[k*8 +: 8];
`endif
      end
    end
  end

  assign last_stage = (stage == num_stages - 8'd1);
  assign win_active = (stage != 8'd0) && (I_window != '0);
  // >= rather than == so a window shrunk mid-stage still expires
  assign win_expired = win_active && (win_cnt >= I_window - pWINDOW_BITS'(1));

`ifdef PW_SEQ_REPEAT_EN
  assign stage_done = (rep_cnt >= rep_target - 8'd1);
`else
  assign stage_done = 1'b1;
`endif

  always_comb begin
    state_nx      = state;
    stage_nx      = stage;
    num_stages_nx = num_stages;
    win_cnt_nx    = win_cnt;
    timeout_nx    = 1'b0;
`ifdef PW_SEQ_REPEAT_EN
    rep_cnt_nx    = rep_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (I_arm) begin
          state_nx      = S_LOAD;
          stage_nx      = '0;
          num_stages_nx = num_clamped;
        end
      end
      S_LOAD: begin
        win_cnt_nx = '0;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (I_match) begin
          if (!stage_done) begin
            state_nx = S_CLEAR;
`ifdef PW_SEQ_REPEAT_EN
            rep_cnt_nx = rep_cnt + 8'd1;
`endif
          end else begin
            state_nx = last_stage ? S_FIRE : S_CLEAR;
            if (!last_stage)
              stage_nx = stage + 8'd1;
`ifdef PW_SEQ_REPEAT_EN
            rep_cnt_nx = '0;
`endif
          end
        end else if (win_expired) begin
          state_nx   = S_CLEAR;
          stage_nx   = '0;
          timeout_nx = 1'b1;
`ifdef PW_SEQ_REPEAT_EN
          rep_cnt_nx = '0;
`endif
        end else if (win_active && (win_cnt != '1)) begin
          win_cnt_nx = win_cnt + pWINDOW_BITS'(1);
        end
      end
      S_CLEAR: state_nx = S_LOAD;
      S_FIRE:  state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase

    if (!I_arm) begin
      state_nx   = S_IDLE;
      stage_nx   = '0;
      timeout_nx = 1'b0;
`ifdef PW_SEQ_REPEAT_EN
      rep_cnt_nx = '0;
`endif
    end
  end

  // Outputs are registered from the next-state decode so they change with the state
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      stage        <= '0;
      num_stages   <= 8'd1;
      win_cnt      <= '0;
      O_pm_arm     <= 1'b0;
      O_pm_clear   <= 1'b1;
      O_pm_pattern <= '0;
      O_pm_mask    <= '0;
      O_pm_bytes   <= '0;
      O_trigger    <= 1'b0;
      O_timeout    <= 1'b0;
      O_busy       <= 1'b0;
    end else begin
      state        <= state_nx;
      stage        <= stage_nx;
      num_stages   <= num_stages_nx;
      win_cnt      <= win_cnt_nx;
      O_pm_arm     <= (state_nx == S_WAIT);
      O_pm_clear   <= (state_nx == S_IDLE) || (state_nx == S_CLEAR) || (state_nx == S_FIRE);
      O_trigger    <= (state_nx == S_FIRE);
      O_timeout    <= timeout_nx;
      O_busy       <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      if (state == S_LOAD) begin
        O_pm_pattern <= sel_pattern;
        O_pm_mask    <= sel_mask;
        O_pm_bytes   <= sel_bytes;
      end
    end
  end

`ifdef PW_SEQ_REPEAT_EN
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt    <= '0;
      rep_target <= 8'd1;
    end else begin
      rep_cnt <= rep_cnt_nx;
      if (state == S_LOAD)
        rep_target <= (sel_repeat == 8'd0) ? 8'd1 : sel_repeat;
    end
  end

  assign O_repeat_cnt = rep_cnt;
`endif

  assign O_stage = stage;

endmodule

// File: tb/tb_pw_pattern_sequencer.sv
// Randomized scenario bench for pw_pattern_sequencer; expectations come from
// per-stage config tables, stage clamping rules and fixed latency/window timing.
module tb_pw_pattern_sequencer;

  localparam int PB = 8;
  localparam int NS = 4;
  localparam int WB = 16;
  localparam int PW = PB * 8;

  logic              fe_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              I_arm = 1'b0;
  logic              I_match = 1'b0;
  logic [7:0]        I_num_stages = '0;
  logic [NS*PW-1:0]  I_stage_pattern = '0;
  logic [NS*PW-1:0]  I_stage_mask = '0;
  logic [NS*8-1:0]   I_stage_bytes = '0;
  logic [WB-1:0]     I_window = '0;
  logic              O_pm_arm, O_pm_clear, O_trigger, O_timeout, O_busy;
  logic [PW-1:0]     O_pm_pattern, O_pm_mask;
  logic [7:0]        O_pm_bytes, O_stage;
`ifdef PW_SEQ_REPEAT_EN
  logic [NS*8-1:0]   I_stage_repeat = {NS{8'd1}};
  logic [7:0]        O_repeat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] pat[NS];
  logic [PW-1:0] msk[NS];
  logic [7:0]    byt[NS];

  pw_pattern_sequencer #(
    .pPATTERN_BYTES(PB),
    .pSTAGES(NS),
    .pWINDOW_BITS(WB)
  ) dut (
    .fe_clk(fe_clk),
    .reset_n(reset_n),
    .I_arm(I_arm),
    .I_num_stages(I_num_stages),
    .I_stage_pattern(I_stage_pattern),
    .I_stage_mask(I_stage_mask),
    .I_stage_bytes(I_stage_bytes),
    .I_window(I_window),
    .I_match(I_match),
`ifdef PW_SEQ_REPEAT_EN
    .I_stage_repeat(I_stage_repeat),
    .O_repeat_cnt(O_repeat_cnt),
`endif
    .O_pm_arm(O_pm_arm),
    .O_pm_pattern(O_pm_pattern),
    .O_pm_mask(O_pm_mask),
    .O_pm_bytes(O_pm_bytes),
    .O_pm_clear(O_pm_clear),
    .O_trigger(O_trigger),
    .O_timeout(O_timeout),
    .O_stage(O_stage),
    .O_busy(O_busy)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic rand_cfg();
    for (int k = 0; k < NS; k++) begin
      pat[k] = {$urandom, $urandom};
      msk[k] = {$urandom, $urandom};
      byt[k] = 8'($urandom_range(0, PB));
      I_stage_pattern[k*PW +: PW] = pat[k];
      I_stage_mask[k*PW +: PW]    = msk[k];
      I_stage_bytes[k*8 +: 8]     = byt[k];
    end
  endtask

  function automatic int eff_stages(input int n);
    if (n == 0) return 1;
    if (n > NS) return NS;
    return n;
  endfunction

  // Enter stage k (from IDLE with I_arm just raised, or from CLEAR), idle d WAIT cycles, then match.
  task automatic run_stage(input int k, input bit last, input int d);
    int n;
    int bad;
    n = 0;
    while (O_pm_arm !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL load_latency stage %0d: got %0d cycles, expected 2", k, n);
    end
    checks++;
    if (O_stage !== 8'(k) || O_pm_pattern !== pat[k] || O_pm_mask !== msk[k] || O_pm_bytes !== byt[k]) begin
      errors++;
      $display("FAIL stage_cfg stage %0d: stage=%0d pat=%h mask=%h bytes=%0d, expected stage=%0d pat=%h mask=%h bytes=%0d",
               k, O_stage, O_pm_pattern, O_pm_mask, O_pm_bytes, k, pat[k], msk[k], byt[k]);
    end
    checks++;
    if (O_busy !== 1'b1 || O_pm_clear !== 1'b0) begin
      errors++;
      $display("FAIL wait_flags stage %0d: busy=%b clear=%b, expected busy=1 clear=0", k, O_busy, O_pm_clear);
    end
    bad = 0;
    for (int i = 0; i < d; i++) begin
      tick();
      if (O_pm_arm !== 1'b1 || O_timeout !== 1'b0 || O_trigger !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_hold stage %0d: %0d of %0d cycles left WAIT, expected 0", k, bad, d);
    end
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    checks++;
    if (last) begin
      if (O_trigger !== 1'b1 || O_pm_clear !== 1'b1 || O_pm_arm !== 1'b0 || O_timeout !== 1'b0) begin
        errors++;
        $display("FAIL fire stage %0d: trig=%b clear=%b arm=%b tmo=%b, expected 1 1 0 0",
                 k, O_trigger, O_pm_clear, O_pm_arm, O_timeout);
      end
    end else begin
      if (O_pm_clear !== 1'b1 || O_pm_arm !== 1'b0 || O_stage !== 8'(k + 1) ||
          O_timeout !== 1'b0 || O_trigger !== 1'b0) begin
        errors++;
        $display("FAIL advance stage %0d: clear=%b arm=%b stage=%0d tmo=%b trig=%b, expected 1 0 %0d 0 0",
                 k, O_pm_clear, O_pm_arm, O_stage, O_timeout, O_trigger, k + 1);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (O_pm_arm !== 1'b0 || O_pm_clear !== 1'b1 || O_busy !== 1'b0 || O_stage !== 8'd0 ||
        O_trigger !== 1'b0 || O_timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s: arm=%b clear=%b busy=%b stage=%0d trig=%b tmo=%b, expected 0 1 0 0 0 0",
               name, O_pm_arm, O_pm_clear, O_busy, O_stage, O_trigger, O_timeout);
    end
  endtask

  task automatic finish_run();
    int trig_seen;
    tick();
    checks++;
    if (O_trigger !== 1'b0 || O_busy !== 1'b0 || O_pm_arm !== 1'b0) begin
      errors++;
      $display("FAIL done_state: trig=%b busy=%b arm=%b, expected 0 0 0", O_trigger, O_busy, O_pm_arm);
    end
    trig_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (O_trigger !== 1'b0 || O_busy !== 1'b0) trig_seen++;
    end
    checks++;
    if (trig_seen != 0) begin
      errors++;
      $display("FAIL done_hold: %0d cycles left DONE or retriggered, expected 0", trig_seen);
    end
    I_arm = 1'b0;
    tick();
    check_idle("done_to_idle");
  endtask

  task automatic run_sequence(input int ncfg, input int win, input bit edge_case);
    int eff;
    int d;
    rand_cfg();
    I_num_stages = 8'(ncfg);
    I_window     = WB'(win);
    eff          = eff_stages(ncfg);
    I_arm        = 1'b1;
    for (int k = 0; k < eff; k++) begin
      if (k == 0) d = $urandom_range(0, 2 * win + 3);
      else if (win == 0) d = $urandom_range(0, 15);
      else if (edge_case) d = win - 1;
      else d = $urandom_range(0, win - 1);
      run_stage(k, k == eff - 1, d);
    end
    finish_run();
  endtask

  task automatic test_reset();
    checks++;
    if (O_pm_arm !== 1'b0 || O_pm_clear !== 1'b1 || O_pm_pattern !== '0 || O_pm_mask !== '0 ||
        O_pm_bytes !== 8'd0 || O_trigger !== 1'b0 || O_timeout !== 1'b0 || O_stage !== 8'd0 || O_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: arm=%b clear=%b pat=%h bytes=%0d trig=%b tmo=%b stage=%0d busy=%b",
               O_pm_arm, O_pm_clear, O_pm_pattern, O_pm_bytes, O_trigger, O_timeout, O_stage, O_busy);
    end
    @(negedge fe_clk);
    reset_n = 1'b1;
    tick();
    check_idle("idle_after_reset");
  endtask

  task automatic test_three_stage();
    run_sequence(3, 0, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    rand_cfg();
    I_num_stages = 8'd2;
    I_window     = WB'(10);
    I_arm        = 1'b1;
    run_stage(0, 1'b0, $urandom_range(0, 8));
    n = 0;
    while (O_pm_arm !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n != 2 || O_stage !== 8'd1 || O_pm_pattern !== pat[1]) begin
      errors++;
      $display("FAIL tmo_stage1_entry: cycles=%0d stage=%0d pat=%h, expected 2 1 %h", n, O_stage, O_pm_pattern, pat[1]);
    end
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (O_timeout !== 1'b0 || O_pm_arm !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL window_early: %0d early exits in first 9 WAIT cycles, expected 0", bad);
    end
    tick();
    checks++;
    if (O_timeout !== 1'b1 || O_stage !== 8'd0 || O_pm_arm !== 1'b0 || O_pm_clear !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: tmo=%b stage=%0d arm=%b clear=%b, expected 1 0 0 1",
               O_timeout, O_stage, O_pm_arm, O_pm_clear);
    end
    tick();
    checks++;
    if (O_timeout !== 1'b0 || O_pm_arm !== 1'b0) begin
      errors++;
      $display("FAIL timeout_one_cycle: tmo=%b arm=%b, expected 0 0", O_timeout, O_pm_arm);
    end
    tick();
    checks++;
    if (O_pm_arm !== 1'b1 || O_stage !== 8'd0 || O_pm_pattern !== pat[0] || O_pm_mask !== msk[0]) begin
      errors++;
      $display("FAIL reload_stage0: arm=%b stage=%0d pat=%h mask=%h, expected 1 0 %h %h",
               O_pm_arm, O_stage, O_pm_pattern, O_pm_mask, pat[0], msk[0]);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (O_timeout !== 1'b0 || O_pm_arm !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stage0_no_timeout: %0d exits during 30 stage-0 WAIT cycles, expected 0", bad);
    end
    I_arm = 1'b0;
    tick();
    check_idle("timeout_abort");
  endtask

  task automatic test_simultaneous();
    run_sequence(2, 10, 1'b1);
    run_sequence(3, 10, 1'b1);
    run_sequence(2, 1, 1'b1);
  endtask

  task automatic test_abort();
    int n;
    int trig_seen;
    rand_cfg();
    I_num_stages = 8'd3;
    I_window     = '0;
    I_arm        = 1'b1;
    run_stage(0, 1'b0, 2);
    n = 0;
    while (O_pm_arm !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (O_stage !== 8'd1 || O_pm_arm !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: stage=%0d arm=%b, expected 1 1", O_stage, O_pm_arm);
    end
    I_arm = 1'b0;
    tick();
    check_idle("abort_wait1");
    trig_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (O_trigger !== 1'b0 || O_busy !== 1'b0) trig_seen++;
    end
    checks++;
    if (trig_seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d active cycles after abort, expected 0", trig_seen);
    end
    I_arm = 1'b1;
    run_stage(0, 1'b0, 1);
    I_arm = 1'b0;
    tick();
    check_idle("abort_clear");
  endtask

  task automatic test_async_reset();
    int n;
    rand_cfg();
    I_num_stages = 8'd2;
    I_window     = '0;
    I_arm        = 1'b1;
    run_stage(0, 1'b0, 1);
    n = 0;
    while (O_pm_arm !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (O_pm_arm !== 1'b0 || O_pm_clear !== 1'b1 || O_pm_pattern !== '0 || O_pm_mask !== '0 ||
        O_pm_bytes !== 8'd0 || O_stage !== 8'd0 || O_busy !== 1'b0 || O_trigger !== 1'b0 || O_timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: arm=%b clear=%b pat=%h bytes=%0d stage=%0d busy=%b, expected 0 1 0 0 0 0",
               O_pm_arm, O_pm_clear, O_pm_pattern, O_pm_bytes, O_stage, O_busy);
    end
    I_arm = 1'b0;
    @(negedge fe_clk);
    reset_n = 1'b1;
    tick();
    check_idle("after_async_reset");
  endtask

  task automatic test_clamp();
    run_sequence(0, 5, 1'b0);
    run_sequence(9, 5, 1'b0);
    run_sequence(255, 0, 1'b0);
  endtask

  task automatic test_random();
    int ncfg;
    int win;
    for (int r = 0; r < 8; r++) begin
      ncfg = $urandom_range(0, 9);
      win  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      run_sequence(ncfg, win, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_three_stage();
    test_timeout();
    test_simultaneous();
    test_abort();
    test_async_reset();
    test_clamp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
